updown_count_bank: RTL and testbench

Bank of `CHANNELS` independent up/down counters, each `WIDTH` bits wide, sharing one programmable prescaler. Each channel has a synchronous load, a programmable upper limit (modulus), a boundary mode (wrap, saturate or reload) and a terminal-count pulse. It is the parametrised successor of the single-channel up/down counter in the FPGA test designs. It targets timer, PWM-base and event-counting workloads that exercise carry chains and wide register banks.

---
 rtl/updown_count_pkg.sv | 27 ++
 rtl/updown_count_bank_if.sv | 27 ++
 rtl/updown_count_channel.sv | 83 ++++++++
 rtl/updown_count_bank.sv | 49 ++++
 tb/tb_updown_count_bank.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/updown_count_pkg.sv
// Shared definitions for the up/down counter bank: boundary-mode encoding,
// per-channel action encoding and the load/limit clamp helper.
package updown_count_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_RELOAD = 2'b10,
        MODE_WRAP2  = 2'b11
    } bound_mode_e;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'b00,
        ACT_LOAD = 2'b01,
        ACT_UP   = 2'b10,
        ACT_DOWN = 2'b11
    } chan_action_e;

    // Widest counter the clamp helper supports; callers size-cast in and out.
    localparam int CLAMP_W = 64;

    function automatic logic [CLAMP_W-1:0] clamp_min(input logic [CLAMP_W-1:0] a,
                                                     input logic [CLAMP_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/updown_count_bank_if.sv
// Control/status bundle of the counter bank: per-channel controls in,
// registered counts and terminal-count pulses out.
interface updown_count_bank_if #(
    parameter int WIDTH          = 8,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 4
);
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       countdown;
    logic [2*CHANNELS-1:0]     mode;
    logic [CHANNELS-1:0]       load;
    logic [WIDTH*CHANNELS-1:0] load_value;
    logic [WIDTH*CHANNELS-1:0] limit;
    logic [WIDTH*CHANNELS-1:0] y;
    logic [CHANNELS-1:0]       tc;

    modport master (
        output prescale, enable, countdown, mode, load, load_value, limit,
        input  y, tc
    );

    modport slave (
        input  prescale, enable, countdown, mode, load, load_value, limit,
        output y, tc
    );
endinterface

// File: rtl/updown_count_channel.sv
// One counter channel: load/step priority, boundary handling per mode and
// the terminal-count pulse, all registered.
module updown_count_channel
    import updown_count_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             enable,
    input  logic             countdown,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] y,
    output logic             tc
);

    chan_action_e     action;
    bound_mode_e      bmode;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] y_nxt;
    logic             tc_nxt;

    assign bmode      = bound_mode_e'(mode);
    assign reload_val = WIDTH'(clamp_min(CLAMP_W'(load_value), CLAMP_W'(limit)));

    always_comb begin
        action = ACT_HOLD;
        if (load) begin
            action = ACT_LOAD;
        end else if (tick && enable) begin
            action = countdown ? ACT_DOWN : ACT_UP;
        end
    end

    // A limit below the current count makes the next up step a boundary step.
    always_comb begin
        y_nxt  = y;
        tc_nxt = 1'b0;
        case (action)
            ACT_LOAD: y_nxt = reload_val;
            ACT_UP: begin
                if (y < limit) begin
                    y_nxt = y + WIDTH'(1);
                end else begin
                    tc_nxt = 1'b1;
                    case (bmode)
                        MODE_SAT:    y_nxt = limit;
                        MODE_RELOAD: y_nxt = reload_val;
                        default:     y_nxt = '0;
                    endcase
                end
            end
            ACT_DOWN: begin
                if (y != '0) begin
                    y_nxt = y - WIDTH'(1);
                end else begin
                    tc_nxt = 1'b1;
                    case (bmode)
                        MODE_SAT:    y_nxt = '0;
                        MODE_RELOAD: y_nxt = reload_val;
                        default:     y_nxt = limit;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y  <= '0;
            tc <= 1'b0;
        end else begin
            y  <= y_nxt;
            tc <= tc_nxt;
        end
    end

endmodule

// File: rtl/updown_count_bank.sv
// Bank of independent up/down counters sharing one programmable prescaler;
// the top holds the prescaler and slices the bus vectors per channel.
module updown_count_bank
    import updown_count_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    updown_count_bank_if.slave bus
);

    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic                      tick;

    assign tick = (pcnt == bus.prescale);

    // A prescale lowered below pcnt lets pcnt run on to all-ones and wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        updown_count_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .resetn     (resetn),
            .tick       (tick),
            .enable     (bus.enable[i]),
            .countdown  (bus.countdown[i]),
            .mode       (bus.mode[2*i +: 2]),
            .load       (bus.load[i]),
            .load_value (bus.load_value[WIDTH*i +: WIDTH]),
            .limit      (bus.limit[WIDTH*i +: WIDTH]),
            .y          (bus.y[WIDTH*i +: WIDTH]),
            .tc         (bus.tc[i])
        );
    end

endmodule

// File: tb/tb_updown_count_bank.sv
// Directed and randomized bench for updown_count_bank against a behavioural
// per-channel model of the counting rules.
module tb_updown_count_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    updown_count_bank_if #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) bus ();

    updown_count_bank #(
        .WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    int my [CH];
    int mtc[CH];
    int ny [CH];
    int ntc[CH];
    int mp, nmp;

    function automatic int ych(input int c);
        return int'(bus.y[W*c +: W]);
    endfunction

    function automatic int tch(input int c);
        return int'(bus.tc[c]);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mp = 0;
        for (int c = 0; c < CH; c++) begin
            my[c]  = 0;
            mtc[c] = 0;
        end
    endtask

    // Next state from the counting rules, using the inputs about to be sampled.
    task automatic model_calc();
        bit tick;
        int lim, lv, md;
        tick = (mp == int'(bus.prescale));
        nmp  = tick ? 0 : (mp + 1) % (1 << PW);
        for (int c = 0; c < CH; c++) begin
            lim    = int'(bus.limit[W*c +: W]);
            lv     = imin(int'(bus.load_value[W*c +: W]), lim);
            md     = int'(bus.mode[2*c +: 2]);
            ny[c]  = my[c];
            ntc[c] = 0;
            if (bus.load[c]) begin
                ny[c] = lv;
            end else if (tick && bus.enable[c]) begin
                if (!bus.countdown[c]) begin
                    if (my[c] < lim) ny[c] = my[c] + 1;
                    else begin
                        ntc[c] = 1;
                        ny[c]  = (md == 1) ? lim : (md == 2) ? lv : 0;
                    end
                end else begin
                    if (my[c] > 0) ny[c] = my[c] - 1;
                    else begin
                        ntc[c] = 1;
                        ny[c]  = (md == 1) ? 0 : (md == 2) ? lv : lim;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_calc();
        @(posedge clk);
        #1;
        mp = nmp;
        for (int c = 0; c < CH; c++) begin
            my[c]  = ny[c];
            mtc[c] = ntc[c];
            check($sformatf("model_y%0d", c), ych(c), my[c]);
            check($sformatf("model_tc%0d", c), tch(c), mtc[c]);
        end
    endtask

    task automatic set_ch(input int c, input bit en, input bit dn, input int md, input int lim);
        bus.enable[c]          = en;
        bus.countdown[c]       = dn;
        bus.mode[2*c +: 2]     = 2'(md);
        bus.limit[W*c +: W]    = W'(lim);
    endtask

    task automatic set_load(input int c, input bit ld, input int lv);
        bus.load[c]              = ld;
        bus.load_value[W*c +: W] = W'(lv);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int ystart;
        int exp_y [4];
        int exp_tc[4];

        resetn         = 1'b0;
        bus.prescale   = '0;
        bus.enable     = '0;
        bus.countdown  = '0;
        bus.mode       = '0;
        bus.load       = '0;
        bus.load_value = '0;
        bus.limit      = '0;

        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            check("reset_y", ych(c), 0);
            check("reset_tc", tch(c), 0);
        end
        resetn = 1'b1;
        model_reset();

        // Wrap mode, limit 5, every-cycle tick
        set_ch(0, 1, 0, 0, 5);
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("wrap_up_y", ych(0), k % 6);
            check("wrap_up_tc", tch(0), (k == 6) ? 1 : 0);
        end
        bus.countdown[0] = 1'b1;
        cycle();
        check("wrap_dn_y", ych(0), 5);
        check("wrap_dn_tc", tch(0), 1);
        cycle();
        check("wrap_dn2_y", ych(0), 4);
        check("wrap_dn2_tc", tch(0), 0);

        // Saturate, limit 200
        set_ch(0, 1, 0, 1, 200);
        set_load(0, 1, 198);
        cycle();
        check("sat_load_y", ych(0), 198);
        set_load(0, 0, 198);
        exp_y  = '{199, 200, 200, 200};
        exp_tc = '{0, 0, 1, 1};
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("sat_up_y", ych(0), exp_y[k]);
            check("sat_up_tc", tch(0), exp_tc[k]);
        end
        set_load(0, 1, 1);
        cycle();
        set_load(0, 0, 1);
        bus.countdown[0] = 1'b1;
        cycle();
        check("sat_dn_y", ych(0), 0);
        check("sat_dn_tc", tch(0), 0);
        cycle();
        check("sat_dn2_y", ych(0), 0);
        check("sat_dn2_tc", tch(0), 1);

        // Reload with clamping
        set_ch(0, 1, 0, 2, 7);
        set_load(0, 1, 6);
        cycle();
        set_load(0, 0, 3);
        cycle();
        check("rel_y1", ych(0), 7);
        check("rel_tc1", tch(0), 0);
        cycle();
        check("rel_y2", ych(0), 3);
        check("rel_tc2", tch(0), 1);
        set_load(0, 1, 250);
        cycle();
        check("clamp_y", ych(0), 7);
        check("clamp_tc", tch(0), 0);

        // Prescaler and load priority
        set_ch(0, 1, 0, 0, 200);
        set_load(0, 1, 0);
        cycle();
        set_load(0, 0, 0);
        bus.prescale = PW'(3);
        ystart = ych(0);
        repeat (12) cycle();
        check("presc_steps", ych(0) - ystart, 3);
        for (int k = 0; k < 8 && mp != 3; k++) cycle();
        set_load(0, 1, 50);
        cycle();
        check("prio_load_y", ych(0), 50);
        check("prio_load_tc", tch(0), 0);
        set_load(0, 0, 50);
        bus.prescale = '0;
        ystart = ych(0);
        repeat (5) cycle();
        check("presc0_steps", ych(0) - ystart, 5);

        // Prescale lowered below the running count
        bus.prescale = PW'(3);
        cycle();
        cycle();
        bus.prescale = PW'(1);
        ystart = ych(0);
        repeat (15) cycle();
        check("presc_lower_hold", ych(0) - ystart, 0);
        cycle();
        check("presc_lower_step", ych(0) - ystart, 1);

        // Limit zero and limit dropped below the count
        bus.prescale = '0;
        set_ch(0, 1, 0, 0, 0);
        set_load(0, 1, 9);
        cycle();
        set_load(0, 0, 0);
        cycle();
        check("lim0_y", ych(0), 0);
        check("lim0_tc", tch(0), 1);
        set_ch(0, 1, 0, 0, 200);
        set_load(0, 1, 100);
        cycle();
        set_load(0, 0, 0);
        bus.limit[0 +: W] = W'(50);
        cycle();
        check("limdrop_up_y", ych(0), 0);
        check("limdrop_up_tc", tch(0), 1);
        set_load(0, 1, 200);
        bus.limit[0 +: W] = W'(200);
        cycle();
        set_load(0, 0, 0);
        bus.limit[0 +: W] = W'(50);
        bus.countdown[0] = 1'b1;
        cycle();
        check("limdrop_dn_y", ych(0), 199);
        check("limdrop_dn_tc", tch(0), 0);

        // Concurrent channels, randomized enables/loads/limits/prescale
        set_ch(0, 1, 0, 0, 9);
        set_ch(1, 1, 1, 1, 13);
        set_ch(2, 1, 0, 2, 20);
        set_ch(3, 1, 1, 3, 6);
        for (int c = 0; c < CH; c++) set_load(c, 1, int'($urandom_range(0, 255)));
        cycle();
        for (int n = 0; n < 1000; n++) begin
            bus.enable = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                set_load(c, ($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)));
                if ($urandom_range(0, 63) == 0)
                    bus.limit[W*c +: W] = W'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 99) == 0) bus.prescale = PW'($urandom_range(0, 3));
            cycle();
        end
        bus.load = '0;

        // Asynchronous reset mid-count, then first tick after release
        bus.prescale = PW'(2);
        set_ch(0, 1, 0, 0, 200);
        repeat (5) cycle();
        #3;
        resetn = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) begin
            check("async_rst_y", ych(c), 0);
            check("async_rst_tc", tch(c), 0);
        end
        @(posedge clk);
        #1;
        check("rst_hold_y", ych(0), 0);
        resetn = 1'b1;
        model_reset();
        cycle();
        check("rel_c1_y", ych(0), 0);
        cycle();
        check("rel_c2_y", ych(0), 0);
        cycle();
        check("rel_c3_y", ych(0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
